membus_join: RTL

Joins one processor memory-bus port to `N_MEM` memory modules.
- Requests are broadcast to every module.
- Responses are merged, and only the acknowledging module's data is admitted onto the return data bus.
- A cycle monitor detects non-existent memory and multiple-acknowledge conflicts.

It sits at system top level between the KA10 port-0 bus signals and the `core161c` instances. It replaces the hard-wired single-module OR wiring used up to now.

---
 rtl/membus_pkg.sv | 25 ++
 rtl/membus_join_if.sv | 41 ++++
 rtl/membus_prio_enc.sv | 37 +++
 rtl/membus_join.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/membus_pkg.sv
// membus_pkg
// Shared constants and types for the processor memory-bus join.
// Contents:
//   WORD_W        data word width (36)
//   MA_LO/MA_HI   processor address range [18:35]
//   MAX_MEM       largest number of memory modules one join serves (16)
//   SEL_W         width of a module index
//   membus_state_e  join FSM state encoding

package membus_pkg;

  localparam int WORD_W  = 36;
  localparam int MA_LO   = 18;
  localparam int MA_HI   = 35;
  localparam int MAX_MEM = 16;
  localparam int SEL_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RS  = 2'd2,
    ST_NXM      = 2'd3
  } membus_state_e;

endpackage

// File: rtl/membus_join_if.sv
// membus_join_if
// Bundles the processor-side bus and the per-module memory signals that
// the join connects.
// Parameter N_MEM: number of memory modules on the memory side.
// Modports:
//   slave  - the join: takes processor requests and module responses,
//            drives the merged acknowledge, restart and data bus
//   master - the processor/module side (used by the bench)
// Module k data occupies mem_mb_out[36k:36k+35].

interface membus_join_if
  import membus_pkg::*;
#(
  parameter int N_MEM = 2
);

  logic                    membus_rd_rq;
  logic                    membus_wr_rq;
  logic                    membus_rq_cyc;
  logic [MA_LO:MA_HI]      membus_ma;
  logic [0:WORD_W-1]       membus_mb_out_p;
  logic                    membus_addr_ack;
  logic                    membus_rd_rs;
  logic [0:WORD_W-1]       membus_mb_in;
  logic [0:N_MEM-1]        mem_addr_ack;
  logic [0:N_MEM-1]        mem_rd_rs;
  logic [0:WORD_W*N_MEM-1] mem_mb_out;

  modport slave (
    input  membus_rd_rq, membus_wr_rq, membus_rq_cyc, membus_ma, membus_mb_out_p,
    input  mem_addr_ack, mem_rd_rs, mem_mb_out,
    output membus_addr_ack, membus_rd_rs, membus_mb_in
  );

  modport master (
    output membus_rd_rq, membus_wr_rq, membus_rq_cyc, membus_ma, membus_mb_out_p,
    output mem_addr_ack, mem_rd_rs, mem_mb_out,
    input  membus_addr_ack, membus_rd_rs, membus_mb_in
  );

endinterface

// File: rtl/membus_prio_enc.sv
// membus_prio_enc
// Lowest-index priority encoder over the module acknowledge lines.
// Ports:
//   req   in  [0:N-1]  request bits, index 0 has highest priority
//   idx   out SEL_W    lowest set index (0 when none set)
//   any   out 1        at least one bit set
//   multi out 1        more than one bit set (always 0 when N = 1)

module membus_prio_enc
  import membus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [0:N-1]     req,
  output logic [SEL_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // Scan upward: the first set bit wins, any later set bit flags multi.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req[k]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          idx = SEL_W'(k);
        end
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/membus_join.sv
// membus_join
// Joins one processor memory-bus port to N_MEM memory modules. Requests
// are broadcast through the shared interface; address acknowledges are
// ORed, and only the acknowledging module's read restart and data reach
// the processor. A cycle monitor latches which module answered, flags
// multiple acknowledges and (optionally) non-existent memory.
// Parameters: N_MEM (1..16), NXM_CYCLES, CNT_W (NXM_CYCLES < 2**CNT_W).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   bus           membus_join_if.slave: processor and module signals
//   nxm           non-existent memory, sticky until the next rq_cyc rise
//   ack_conflict  more than one module acknowledged, sticky until reset
//   ack_sel       index of the module that acknowledged the cycle
// Build option: define MEMBUS_NXM_EN to build the timeout counter, the
// NXM state and the nxm flag. Without it WAIT_ACK waits indefinitely
// (the processor runs its own timeout) and nxm is tied low.

module membus_join
  import membus_pkg::*;
#(
  parameter int N_MEM      = 2,
  parameter int NXM_CYCLES = 100,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  membus_join_if.slave     bus,
  output logic             nxm,
  output logic             ack_conflict,
  output logic [SEL_W-1:0] ack_sel
);

  if (N_MEM < 1 || N_MEM > MAX_MEM) begin : g_bad_n_mem
    $error("membus_join: N_MEM must be 1..16");
  end
  if (NXM_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("membus_join: CNT_W too narrow for NXM_CYCLES");
  end

  membus_state_e     state_q, state_d;
  logic              rq_cyc_q;
  logic              rq_rise;
  logic              is_read_q, is_read_d;
  logic [SEL_W-1:0]  ack_sel_q, ack_sel_d;
  logic              conflict_q, conflict_d;
  logic [SEL_W-1:0]  enc_idx;
  logic              enc_any, enc_multi;
  logic              sel_rs;
  logic [0:WORD_W-1] sel_data;
  logic              fwd;
  logic              syn_ack, syn_rs;

`ifdef MEMBUS_NXM_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              nxm_q, nxm_d;
  logic              nxm_rs_q, nxm_rs_d;
`endif

  membus_prio_enc #(.N(N_MEM)) u_prio_enc (
    .req   (bus.mem_addr_ack),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Previous rq_cyc for edge detection. Deliberately not reset, so a
  // request cycle still held high across a reset is not seen as a new rise.
  always_ff @(posedge clk) begin
    rq_cyc_q <= bus.membus_rq_cyc;
  end

  assign rq_rise = bus.membus_rq_cyc & ~rq_cyc_q;

  // Pick the latched module's read restart and data word.
  always_comb begin
    sel_rs   = 1'b0;
    sel_data = '0;
    for (int k = 0; k < N_MEM; k++) begin
      if (ack_sel_q == SEL_W'(k)) begin
        sel_rs   = bus.mem_rd_rs[k];
        sel_data = bus.mem_mb_out[WORD_W*k +: WORD_W];
      end
    end
  end

  assign fwd = (state_q == ST_WAIT_RS);

`ifdef MEMBUS_NXM_EN
  assign syn_ack = (state_q == ST_NXM) && !nxm_rs_q;
  assign syn_rs  = (state_q == ST_NXM) && nxm_rs_q;
  assign nxm     = nxm_q;
`else
  assign syn_ack = 1'b0;
  assign syn_rs  = 1'b0;
  assign nxm     = 1'b0;
`endif

  // Merged responses: zero added latency, gated only by the FSM state.
  assign bus.membus_addr_ack = (|bus.mem_addr_ack) | syn_ack;
  assign bus.membus_rd_rs    = (fwd & sel_rs) | syn_rs;
  assign bus.membus_mb_in    = bus.membus_mb_out_p | (fwd ? sel_data : '0);

  assign ack_sel      = ack_sel_q;
  assign ack_conflict = conflict_q;

  // Cycle monitor next-state logic. A real ack in the cycle the counter
  // reaches NXM_CYCLES wins over the timeout because it is tested first.
  always_comb begin
    state_d    = state_q;
    is_read_d  = is_read_q;
    ack_sel_d  = ack_sel_q;
    conflict_d = conflict_q;
`ifdef MEMBUS_NXM_EN
    cnt_d      = cnt_q;
    nxm_d      = nxm_q;
    nxm_rs_d   = nxm_rs_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rq_rise) begin
          state_d   = ST_WAIT_ACK;
          is_read_d = bus.membus_rd_rq;
`ifdef MEMBUS_NXM_EN
          cnt_d     = '0;
          nxm_d     = 1'b0;
          nxm_rs_d  = 1'b0;
`endif
        end
      end
      ST_WAIT_ACK: begin
`ifdef MEMBUS_NXM_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (!bus.membus_rq_cyc) begin
          state_d = ST_IDLE;
        end else if (enc_any) begin
          ack_sel_d = enc_idx;
          if (enc_multi) begin
            conflict_d = 1'b1;
          end
          state_d = is_read_q ? ST_WAIT_RS : ST_IDLE;
        end
`ifdef MEMBUS_NXM_EN
        else if (cnt_d == CNT_W'(NXM_CYCLES)) begin
          state_d  = ST_NXM;
          nxm_d    = 1'b1;
          nxm_rs_d = 1'b0;
        end
`endif
      end
      ST_WAIT_RS: begin
        if (!bus.membus_rq_cyc || sel_rs) begin
          state_d = ST_IDLE;
        end
      end
      ST_NXM: begin
`ifdef MEMBUS_NXM_EN
        // First NXM cycle is the synthetic ack; reads get a restart next.
        if (is_read_q && !nxm_rs_q) begin
          nxm_rs_d = 1'b1;
        end else begin
          nxm_rs_d = 1'b0;
          state_d  = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      is_read_q  <= 1'b0;
      ack_sel_q  <= '0;
      conflict_q <= 1'b0;
`ifdef MEMBUS_NXM_EN
      cnt_q      <= '0;
      nxm_q      <= 1'b0;
      nxm_rs_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      is_read_q  <= is_read_d;
      ack_sel_q  <= ack_sel_d;
      conflict_q <= conflict_d;
`ifdef MEMBUS_NXM_EN
      cnt_q      <= cnt_d;
      nxm_q      <= nxm_d;
      nxm_rs_q   <= nxm_rs_d;
`endif
    end
  end

endmodule
